uart_transmitter: RTL and testbench
===================================

# uart_transmitter

8N1 UART transmitter, the transmit-side counterpart to the board's UART receive path. Accepts bytes from the system over a valid/ready handshake into a small FIFO and serialises them LSB-first on `tx`, with one start and one stop bit. Back-to-back frames are emitted without idle gaps. Sits between the system interconnect (or debug host logic) and the UART TX pin.

## Interface
- `clk_freq`, 100000000: clock frequency in Hz.
- `baud_rate`, 115200: line rate in baud.
- `fifo_depth_log2`, 2: FIFO holds 2^`fifo_depth_log2` bytes (default 4).
- `clk` input 1: sole clock; all logic on posedge.
- `reset_n` input 1: asynchronous, active-low reset.
- `data` input 8: byte to send.
- `data_valid` input 1: write request; qualified by `ready`.
- `ready` output 1: FIFO not full.
- `tx` output 1: serial line, registered, idle high.
- `busy` output 1: high while the FIFO is non-empty or a frame is in flight.

## Operation
- `bit_cycles` = `clk_freq / baud_rate`, using integer division.
  - Compile-time requirement: `bit_cycles` ≥ 2.
  - The bit counter is `$clog2(bit_cycles)` wide and counts 0..`bit_cycles`-1.
- Write handshake:
  - A byte is accepted on a posedge where `data_valid && ready`.
  - `ready = !full`, from registered pointers only. A simultaneous pop does not open a slot in the same cycle.
  - Writes while full are dropped; the byte is not captured.
- FIFO: pointers are `fifo_depth_log2`+1 bits wide. Empty means the pointers are equal. Full means the MSBs differ and the rest are equal. Pointers wrap modulo 2^(`fifo_depth_log2`+1).
- FSM states `IDLE`, `START`, `DATA`, `STOP`:
  - `IDLE`: if the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit counter, go to `START`. `tx`=1.
  - `START`: `tx`=0 for `bit_cycles` cycles. Then clear `bit_index` and go to `DATA`.
  - `DATA`: `tx`=shift[0] for `bit_cycles` cycles per bit. At each bit end, shift right and increment `bit_index` (3 bits). After bit 7, go to `STOP`.
  - `STOP`: `tx`=1 for `bit_cycles` cycles. At the end:
    - if the FIFO is non-empty, pop and go directly to `START` (no idle cycle);
    - otherwise go to `IDLE`.
  - Unreachable encodings go to `IDLE`.
- `busy` = (state != `IDLE`) || !empty, registered.
- Reset (asserted at any time, including mid-frame):
  - Outputs: `tx`=1, `ready`=1, `busy`=0.
  - Internal: FSM=`IDLE`, FIFO pointers=0, shift register=0.
  - Effect: the frame in progress is truncated and queued bytes are discarded.

## Timing
- Write at posedge N into an empty FIFO in `IDLE`: pop at N+1, `tx` falls at posedge N+2.
- Frame length is exactly 10·`bit_cycles` cycles from `tx` falling to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `ready` deasserts on the posedge after the write that fills the FIFO, and reasserts on the posedge after the pop that frees a slot.
- `busy` falls one cycle after `IDLE` is entered with the FIFO empty.

## Structure
- Package `uart_pkg`:
  - FSM state enum (`IDLE`, `START`, `DATA`, `STOP`).
  - `UART_DATA_BITS`=8.
  - A function computing `bit_cycles` from `clk_freq` and `baud_rate`.
- Sub-module `uart_tx_fifo`:
  - Parameterised by `fifo_depth_log2`.
  - Ports: write (`data`, `wr_en`), read (`q`, `rd_en`), `empty`, `full`.
  - Async active-low reset.
- Baud counter and FSM live in the top module.

## Test plan
Bench parameters: `clk_freq`=16, `baud_rate`=1 (so `bit_cycles`=16), `fifo_depth_log2`=2.
- Reset: hold `reset_n`=0 → `tx`=1, `ready`=1, `busy`=0. Assert `reset_n` mid-clock → `tx`=1 before the next edge.
- Single byte 0x55 at cycle N → `tx`=0 at N+2, then 16-cycle bits 1,0,1,0,1,0,1,0, stop=1 through N+161; `busy`=0 by N+163.
- Back-to-back writes 0xA3, 0x0F → 320 contiguous frame cycles; data bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0; no idle cycle between frames.
- Overflow: 6 consecutive writes 0x01..0x06 while idle →
  - 0x01 is popped; 0x02–0x05 fill the FIFO, and `ready`=0 after the 5th write;
  - 0x06 is dropped;
  - exactly five frames are sent, 0x01..0x05.
- Reset mid-frame: assert `reset_n`=0 during data bit 3 of 0xC3 with 2 bytes queued → `tx`=1 immediately; after release, `busy`=0, `ready`=1, no further frames.
- Loopback: default parameters, `tx` wired to the UART receiver → bytes 0x00, 0xFF, 0x5A produce matching `data`/`data_ready` pulses in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    function automatic int unsigned calc_bit_cycles(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte write handshake into the UART transmitter: the system drives data/data_valid,
// the transmitter answers with ready.
interface uart_transmitter_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      data_valid;
    logic                      ready;

    modport master (
        output data,
        output data_valid,
        input  ready
    );

    modport slave (
        input  data,
        input  data_valid,
        output ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; pointers carry an extra wrap bit so full and
// empty can be told apart without a separate counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned fifo_depth_log2 = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      wr_en,
    output logic [UART_DATA_BITS-1:0] q,
    input  logic                      rd_en,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned Depth = 1 << fifo_depth_log2;

    logic [fifo_depth_log2:0]  wr_ptr_q, wr_ptr_d;
    logic [fifo_depth_log2:0]  rd_ptr_q, rd_ptr_d;
    logic [UART_DATA_BITS-1:0] mem_q [Depth];
    logic                      do_wr, do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[fifo_depth_log2] != rd_ptr_q[fifo_depth_log2]) &&
                   (wr_ptr_q[fifo_depth_log2-1:0] == rd_ptr_q[fifo_depth_log2-1:0]);
    assign q     = mem_q[rd_ptr_q[fifo_depth_log2-1:0]];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible once a pointer covers them.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[fifo_depth_log2-1:0]] <= data;
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: FIFO-buffered bytes are shifted out LSB-first with one start
// and one stop bit; queued bytes follow each other with no idle gap.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq        = 100000000,
    parameter int unsigned baud_rate       = 115200,
    parameter int unsigned fifo_depth_log2 = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_transmitter_if.slave  in_if,
    output logic               tx,
    output logic               busy
);

    localparam int unsigned BitCycles = calc_bit_cycles(clk_freq, baud_rate);
    localparam int unsigned CntW      = $clog2(BitCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(BitCycles - 1);

    if (BitCycles < 2) begin : g_bit_cycles_check
        $error("uart_transmitter: clk_freq / baud_rate must be at least 2");
    end

    uart_state_e               state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic [UART_DATA_BITS-1:0] fifo_q;
    logic                      fifo_empty, fifo_full, fifo_wr, fifo_rd;
    logic                      bit_end;

    assign in_if.ready = !fifo_full;
    assign fifo_wr     = in_if.data_valid && !fifo_full;

    uart_tx_fifo #(
        .fifo_depth_log2(fifo_depth_log2)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .data   (in_if.data),
        .wr_en  (fifo_wr),
        .q      (fifo_q),
        .rd_en  (fifo_rd),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_rd   = 1'b0;
        if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + CntW'(1);

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_q;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        shift_d = fifo_q;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != StIdle) || !fifo_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: line activity is compared cycle by cycle
// against an ideal 8N1 waveform built from the byte list.
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int unsigned ClkFreq   = 16;
    localparam int unsigned BaudRate  = 1;
    localparam int unsigned DepthLog2 = 2;
    localparam int          BitCyc    = 16;
    localparam int          FrameCyc  = 10 * BitCyc;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic reset_n;
    logic tx, busy;
    int   checks = 0;
    int   errors = 0;

    uart_transmitter_if bus_if ();

    uart_transmitter #(
        .clk_freq       (ClkFreq),
        .baud_rate      (BaudRate),
        .fifo_depth_log2(DepthLog2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in_if  (bus_if),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Ideal line level f cycles after the first start bit begins, frames back to back.
    function automatic logic model_tx(input byte_q_t frames, input int f);
        int         fr, b;
        logic [7:0] v;
        if (f < 0 || f >= FrameCyc * frames.size()) return 1'b1;
        fr = f / FrameCyc;
        b  = (f % FrameCyc) / BitCyc;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        v = frames[fr];
        return v[b-1];
    endfunction

    // One byte per clock; returns 1ns after the last write edge.
    task automatic write_bytes(input byte_q_t q);
        foreach (q[i]) begin
            bus_if.data       = q[i];
            bus_if.data_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus_if.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus_if.data       = '0;
        bus_if.data_valid = 1'b0;
        #22;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++;
        if (bus_if.ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", bus_if.ready);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle got tx=%b busy=%b ready=%b exp 1 0 1",
                     tx, busy, bus_if.ready);
        end
    endtask

    task automatic test_single_byte();
        byte_q_t q;
        logic    exp;
        q = {8'h55};
        write_bytes(q);
        for (int k = 0; k <= 165; k++) begin
            @(negedge clk);
            exp = model_tx(q, k - 2);
            checks++;
            if (tx !== exp) begin
                errors++; $display("FAIL single_tx k=%0d got %b exp %b", k, tx, exp);
            end
            if (k == 1 || k == 100 || k == 163) begin
                checks++;
                if (busy !== (k != 163)) begin
                    errors++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, k != 163);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t q;
        logic    exp;
        q = {8'hA3, 8'h0F};
        write_bytes(q);
        for (int k = 1; k <= 330; k++) begin
            @(negedge clk);
            exp = model_tx(q, k - 2);
            checks++;
            if (tx !== exp) begin
                errors++; $display("FAIL b2b_tx k=%0d got %b exp %b", k, tx, exp);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_overflow();
        byte_q_t q;
        logic    exp;
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < 6; i++) begin
            bus_if.data       = 8'(i + 1);
            bus_if.data_valid = 1'b1;
            @(posedge clk);
            #1;
            // First byte moves into the shifter, so the 4-deep FIFO fills on write 5.
            checks++;
            if (bus_if.ready !== (i < 4)) begin
                errors++; $display("FAIL ovf_ready write=%0d got %b exp %b", i + 1,
                                   bus_if.ready, i < 4);
            end
        end
        bus_if.data_valid = 1'b0;
        for (int k = 5; k <= 812; k++) begin
            @(negedge clk);
            exp = model_tx(q, k - 2);
            checks++;
            if (tx !== exp) begin
                errors++; $display("FAIL ovf_tx k=%0d got %b exp %b", k, tx, exp);
            end
            if (k == 160 || k == 161) begin
                checks++;
                if (bus_if.ready !== (k == 161)) begin
                    errors++; $display("FAIL ovf_ready_reopen k=%0d got %b exp %b", k,
                                       bus_if.ready, k == 161);
                end
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_random();
        byte_q_t q;
        int      n;
        logic    exp;
        for (int r = 0; r < 3; r++) begin
            q = {};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            write_bytes(q);
            for (int k = n - 1; k <= n * FrameCyc + 4; k++) begin
                @(negedge clk);
                exp = model_tx(q, k - 2);
                checks++;
                if (tx !== exp) begin
                    errors++; $display("FAIL rand_tx round=%0d k=%0d got %b exp %b", r, k, tx, exp);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL rand_busy_end round=%0d got %b exp 0", r, busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t q;
        logic    exp;
        int      bad;
        q = {8'hC3, 8'($urandom), 8'($urandom)};
        write_bytes(q);
        // Sample point 74 lies in the middle of data bit 3 of 0xC3.
        for (int k = 2; k <= 74; k++) begin
            @(negedge clk);
            exp = model_tx(q, k - 2);
            checks++;
            if (tx !== exp) begin
                errors++; $display("FAIL rstmid_tx k=%0d got %b exp %b", k, tx, exp);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || bus_if.ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got tx=%b ready=%b busy=%b exp 1 1 0",
                     tx, bus_if.ready, busy);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || bus_if.ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad);
        end
    endtask

    // Independent mid-bit sampling receiver on tx.
    task automatic test_loopback();
        byte_q_t    q;
        logic [7:0] rx;
        int         waited;
        q = {8'h00, 8'hFF, 8'h5A};
        write_bytes(q);
        foreach (q[i]) begin
            waited = 0;
            @(negedge clk);
            while (tx !== 1'b0 && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (waited >= 400) begin
                errors++; $display("FAIL loop_start_timeout byte=%0d got none exp start", i);
                return;
            end
            repeat (BitCyc / 2) @(negedge clk);
            checks++;
            if (tx !== 1'b0) begin errors++; $display("FAIL loop_start byte=%0d got %b exp 0", i, tx); end
            for (int b = 0; b < 8; b++) begin
                repeat (BitCyc) @(negedge clk);
                rx[b] = tx;
            end
            repeat (BitCyc) @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL loop_stop byte=%0d got %b exp 1", i, tx); end
            checks++;
            if (rx !== q[i]) begin
                errors++; $display("FAIL loop_data byte=%0d got %h exp %h", i, rx, q[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy_end got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid_frame();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
